// File: rtl/lane_judge_engine.sv
`default_nettype none
// ============================================================================
// Module      : lane_judge_engine
// Description : Parametrised multi-lane hit judge and scorer. Holds one
//               pending note per lane, grades key presses PERFECT/GOOD
//               against the note time, expires unhit notes as MISS, and
//               keeps a saturating score, combo and max combo.
// Revision    : 1.0 - initial release
// ============================================================================
module lane_judge_engine #(
  parameter int LANES       = 8,
  parameter int TIME_W      = 10,
  parameter int PERFECT_WIN = 1,
  parameter int GOOD_WIN    = 3,
  parameter int PERFECT_PTS = 2,
  parameter int GOOD_PTS    = 1,
  parameter int SCORE_W     = 11,
  parameter int COMBO_W     = 8,
  localparam int LANE_W     = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic [TIME_W-1:0]   game_time_i,
  input  logic                note_valid_i,
  input  logic [LANES-1:0]    note_lanes_i,
  input  logic [TIME_W-1:0]   note_time_i,
  output logic                note_ready_o,
  input  logic [LANES-1:0]    key_in_i,
  output logic                judge_valid_o,
  output logic [1:0]          judge_grade_o,
  output logic [LANE_W-1:0]   judge_lane_o,
  output logic [SCORE_W-1:0]  score_o,
  output logic [COMBO_W-1:0]  combo_o,
  output logic [COMBO_W-1:0]  max_combo_o
);

  // Window bounds as signed TIME_W values so delta comparisons stay same-width
  localparam logic signed [TIME_W-1:0] C_PERF_POS = TIME_W'(PERFECT_WIN);
  localparam logic signed [TIME_W-1:0] C_PERF_NEG = TIME_W'(-PERFECT_WIN);
  localparam logic signed [TIME_W-1:0] C_GOOD_POS = TIME_W'(GOOD_WIN);
  localparam logic signed [TIME_W-1:0] C_GOOD_NEG = TIME_W'(-GOOD_WIN);

  localparam logic [31:0] C_SCORE_MAX = 32'((64'd1 << SCORE_W) - 64'd1);
  localparam logic [31:0] C_COMBO_MAX = 32'((64'd1 << COMBO_W) - 64'd1);

  localparam logic [1:0] C_GRADE_NONE    = 2'b00;
  localparam logic [1:0] C_GRADE_MISS    = 2'b01;
  localparam logic [1:0] C_GRADE_GOOD    = 2'b10;
  localparam logic [1:0] C_GRADE_PERFECT = 2'b11;

  logic [LANES-1:0]   busy_q;
  logic [LANES-1:0]   busy_d;
  logic [LANES-1:0]   key_q;
  logic [LANES-1:0]   w_press;
  logic [LANES-1:0]   w_perfect;
  logic [LANES-1:0]   w_good;
  logic [LANES-1:0]   w_miss;
  logic [LANES-1:0]   w_resolved;
  logic               w_accept;

  logic [SCORE_W-1:0] score_q, score_d;
  logic [COMBO_W-1:0] combo_q, combo_d;
  logic [COMBO_W-1:0] max_combo_q, max_combo_d;
  logic               judge_valid_q, judge_valid_d;
  logic [1:0]         judge_grade_q, judge_grade_d;
  logic [LANE_W-1:0]  judge_lane_q, judge_lane_d;

  logic [31:0]        w_pts;
  logic [31:0]        w_hits;
  logic               w_any_miss;
  logic [31:0]        w_score_sum;
  logic [31:0]        w_combo_sum;

  // A note may only enter when none of its lanes still holds a pending note
  assign note_ready_o = ~|(note_lanes_i & busy_q);
  assign w_accept     = note_valid_i & note_ready_o;
  assign w_press      = key_in_i & ~key_q;
  assign w_resolved   = w_perfect | w_good | w_miss;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [TIME_W-1:0]        slot_time_q;
    logic signed [TIME_W-1:0] w_delta;
    logic                     w_in_perfect;
    logic                     w_in_good;

    // Wrap-safe distance from the note: positive means the note is late
    assign w_delta      = $signed(game_time_i - slot_time_q);
    assign w_in_perfect = (w_delta >= C_PERF_NEG) && (w_delta <= C_PERF_POS);
    assign w_in_good    = (w_delta >= C_GOOD_NEG) && (w_delta <= C_GOOD_POS);

    assign w_perfect[l] = busy_q[l] & w_press[l] & w_in_perfect;
    assign w_good[l]    = busy_q[l] & w_press[l] & ~w_in_perfect & w_in_good;
    assign w_miss[l]    = busy_q[l] & (w_delta > C_GOOD_POS);

    // Resolved slots free up; a newly accepted note claims its lanes
    assign busy_d[l] = (busy_q[l] & ~w_resolved[l]) | (w_accept & note_lanes_i[l]);

    // Per-lane pending slot: occupancy flag and target time
    always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
        busy_q[l]   <= 1'b0;
        slot_time_q <= '0;
      end else begin
        busy_q[l] <= busy_d[l];
        if (w_accept && note_lanes_i[l]) begin
          slot_time_q <= note_time_i;
        end
      end
    end
  end

  // Tally points and hits across lanes and pick the lowest resolved lane for reporting
  always_comb begin
    w_pts         = '0;
    w_hits        = '0;
    w_any_miss    = 1'b0;
    judge_grade_d = C_GRADE_NONE;
    judge_lane_d  = '0;
    for (int l = 0; l < LANES; l++) begin
      if (w_perfect[l]) begin
        w_pts  = w_pts + 32'(PERFECT_PTS);
        w_hits = w_hits + 32'd1;
      end
      if (w_good[l]) begin
        w_pts  = w_pts + 32'(GOOD_PTS);
        w_hits = w_hits + 32'd1;
      end
      if (w_miss[l]) begin
        w_any_miss = 1'b1;
      end
    end
    for (int l = LANES - 1; l >= 0; l--) begin
      if (w_resolved[l]) begin
        judge_lane_d = LANE_W'(l);
        if (w_perfect[l]) begin
          judge_grade_d = C_GRADE_PERFECT;
        end else if (w_good[l]) begin
          judge_grade_d = C_GRADE_GOOD;
        end else begin
          judge_grade_d = C_GRADE_MISS;
        end
      end
    end
    judge_valid_d = |w_resolved;
  end

  // Saturating score/combo update; any miss breaks the combo outright
  always_comb begin
    w_score_sum = 32'(score_q) + w_pts;
    w_combo_sum = 32'(combo_q) + w_hits;
    score_d = (w_score_sum > C_SCORE_MAX) ? C_SCORE_MAX[SCORE_W-1:0]
                                          : w_score_sum[SCORE_W-1:0];
    if (w_any_miss) begin
      combo_d = '0;
    end else if (w_combo_sum > C_COMBO_MAX) begin
      combo_d = C_COMBO_MAX[COMBO_W-1:0];
    end else begin
      combo_d = w_combo_sum[COMBO_W-1:0];
    end
    max_combo_d = (combo_d > max_combo_q) ? combo_d : max_combo_q;
  end

  // Result registers and key history for edge detection
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      key_q         <= '0;
      score_q       <= '0;
      combo_q       <= '0;
      max_combo_q   <= '0;
      judge_valid_q <= 1'b0;
      judge_grade_q <= C_GRADE_NONE;
      judge_lane_q  <= '0;
    end else begin
      key_q         <= key_in_i;
      score_q       <= score_d;
      combo_q       <= combo_d;
      max_combo_q   <= max_combo_d;
      judge_valid_q <= judge_valid_d;
      judge_grade_q <= judge_grade_d;
      judge_lane_q  <= judge_lane_d;
    end
  end

  assign judge_valid_o = judge_valid_q;
  assign judge_grade_o = judge_grade_q;
  assign judge_lane_o  = judge_lane_q;
  assign score_o       = score_q;
  assign combo_o       = combo_q;
  assign max_combo_o   = max_combo_q;

endmodule
`default_nettype wire

// File: tb/tb_lane_judge_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_lane_judge_engine
// Description : Directed scenarios plus randomized traffic for
//               lane_judge_engine, checked against a lane-level game model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lane_judge_engine;
  localparam int LANES = 8;
  localparam int TW    = 10;
  localparam int TMOD  = 1024;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [TW-1:0] game_time = '0;
  logic          note_valid = 1'b0;
  logic [7:0]    note_lanes = '0;
  logic [TW-1:0] note_time = '0;
  logic [7:0]    key_in = '0;
  logic          note_ready;
  logic          judge_valid;
  logic [1:0]    judge_grade;
  logic [2:0]    judge_lane;
  logic [10:0]   score;
  logic [7:0]    combo;
  logic [7:0]    max_combo;

  lane_judge_engine dut (
    .clock_i      (clock),
    .reset_i      (reset),
    .game_time_i  (game_time),
    .note_valid_i (note_valid),
    .note_lanes_i (note_lanes),
    .note_time_i  (note_time),
    .note_ready_o (note_ready),
    .key_in_i     (key_in),
    .judge_valid_o(judge_valid),
    .judge_grade_o(judge_grade),
    .judge_lane_o (judge_lane),
    .score_o      (score),
    .combo_o      (combo),
    .max_combo_o  (max_combo)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Game model: one pending note per lane, plus running totals
  bit       m_busy [LANES];
  int       m_time [LANES];
  bit [7:0] m_key;
  int       m_score, m_combo, m_max;
  int       e_valid, e_grade, e_lane;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sdelta(int gt, int t);
    int d;
    d = (((gt - t) % TMOD) + TMOD) % TMOD;
    if (d >= TMOD / 2) d = d - TMOD;
    return d;
  endfunction

  task automatic model_reset();
    for (int l = 0; l < LANES; l++) begin
      m_busy[l] = 0;
      m_time[l] = 0;
    end
    m_key = '0; m_score = 0; m_combo = 0; m_max = 0;
    e_valid = 0; e_grade = 0; e_lane = 0;
  endtask

  // One clock cycle: drive inputs, check the handshake, advance the model, check results
  task automatic tick(int gt, bit nv, bit [7:0] nl, int nt, bit [7:0] k);
    bit ready;
    int pts, hits, first, grade;
    bit miss;
    game_time  = gt[TW-1:0];
    note_valid = nv;
    note_lanes = nl;
    note_time  = nt[TW-1:0];
    key_in     = k;
    #1;
    ready = 1;
    for (int l = 0; l < LANES; l++) if (nl[l] && m_busy[l]) ready = 0;
    check("note_ready", 32'(note_ready), 32'(ready));

    pts = 0; hits = 0; miss = 0; first = -1; grade = 0;
    for (int l = 0; l < LANES; l++) begin
      int g = 0;
      if (m_busy[l]) begin
        int  d     = sdelta(gt, m_time[l]);
        bit  press = k[l] && !m_key[l];
        if (press && d >= -1 && d <= 1)      g = 3;
        else if (press && d >= -3 && d <= 3) g = 2;
        else if (d > 3)                      g = 1;
      end
      if (g != 0) begin
        if (first < 0) begin first = l; grade = g; end
        m_busy[l] = 0;
        if (g == 3) begin pts += 2; hits++; end
        if (g == 2) begin pts += 1; hits++; end
        if (g == 1) miss = 1;
      end
    end
    if (nv && ready) begin
      for (int l = 0; l < LANES; l++) begin
        if (nl[l]) begin
          m_busy[l] = 1;
          m_time[l] = ((nt % TMOD) + TMOD) % TMOD;
        end
      end
    end
    m_key   = k;
    m_score = (m_score + pts > 2047) ? 2047 : m_score + pts;
    m_combo = miss ? 0 : ((m_combo + hits > 255) ? 255 : m_combo + hits);
    if (m_combo > m_max) m_max = m_combo;
    e_valid = (first >= 0) ? 1 : 0;
    e_grade = (first >= 0) ? grade : 0;
    e_lane  = (first >= 0) ? first : 0;

    @(posedge clock);
    #1;
    check("judge_valid", 32'(judge_valid), 32'(e_valid));
    check("judge_grade", 32'(judge_grade), 32'(e_grade));
    check("judge_lane",  32'(judge_lane),  32'(e_lane));
    check("score",       32'(score),       32'(m_score));
    check("combo",       32'(combo),       32'(m_combo));
    check("max_combo",   32'(max_combo),   32'(m_max));
  endtask

  initial begin
    int rg;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("rst_valid", 32'(judge_valid), 0);
    check("rst_grade", 32'(judge_grade), 0);
    check("rst_score", 32'(score), 0);
    check("rst_ready", 32'(note_ready), 1);
    reset = 1'b0;

    // Exact PERFECT on lane 2
    tick(98, 1, 8'h04, 100, 8'h00);
    tick(99, 0, 8'h00, 0, 8'h00);
    tick(100, 0, 8'h00, 0, 8'h04);
    check("s1_grade", 32'(judge_grade), 3);
    check("s1_lane",  32'(judge_lane), 2);
    check("s1_score", 32'(score), 2);
    check("s1_combo", 32'(combo), 1);

    // GOOD at +3, then press at +4 ignored and the note expires as MISS
    tick(48, 1, 8'h01, 50, 8'h00);
    tick(53, 0, 8'h00, 0, 8'h01);
    check("s2_good", 32'(judge_grade), 2);
    check("s2_score", 32'(score), 3);
    tick(52, 1, 8'h01, 50, 8'h00);
    tick(54, 0, 8'h00, 0, 8'h01);
    check("s2_miss", 32'(judge_grade), 1);
    check("s2_combo", 32'(combo), 0);

    // Chord {1,4}: lanes stay busy until judged
    tick(198, 1, 8'h12, 200, 8'h00);
    tick(199, 1, 8'h02, 300, 8'h00);
    check("s3_ready", 32'(note_ready), 0);
    tick(200, 0, 8'h00, 0, 8'h12);
    check("s3_lane",  32'(judge_lane), 1);
    check("s3_score", 32'(score), 7);
    check("s3_combo", 32'(combo), 2);

    // Reach combo 5, then PERFECT and MISS in the same cycle
    tick(298, 1, 8'h07, 300, 8'h00);
    tick(300, 0, 8'h00, 0, 8'h07);
    check("s4_combo5", 32'(combo), 5);
    tick(395, 1, 8'h01, 400, 8'h00);
    tick(395, 1, 8'h08, 396, 8'h00);
    tick(400, 0, 8'h00, 0, 8'h01);
    check("s4_combo", 32'(combo), 0);
    check("s4_max",   32'(max_combo), 5);
    check("s4_grade", 32'(judge_grade), 3);
    check("s4_score", 32'(score), 15);

    // Wrap-around GOOD, then a held key never re-triggers
    tick(1020, 1, 8'h04, 1022, 8'h00);
    tick(0, 0, 8'h00, 0, 8'h04);
    check("s5_wrap", 32'(judge_grade), 2);
    tick(1, 1, 8'h04, 2, 8'h04);
    tick(2, 0, 8'h00, 0, 8'h04);
    check("s5_held", 32'(judge_valid), 0);
    tick(6, 0, 8'h00, 0, 8'h04);
    check("s5_miss", 32'(judge_grade), 1);

    // Drive score to saturation with full-width chords then single lanes
    while (m_score < 2030) begin
      tick(500, 1, 8'hFF, 500, 8'h00);
      tick(500, 0, 8'h00, 0, 8'hFF);
    end
    check("s6_combo_sat", 32'(combo), 255);
    while (m_score < 2045) begin
      tick(500, 1, 8'h01, 500, 8'h00);
      tick(500, 0, 8'h00, 0, 8'h01);
    end
    repeat (2) begin
      tick(500, 1, 8'h01, 500, 8'h00);
      tick(500, 0, 8'h00, 0, 8'h01);
    end
    check("s6_sat", 32'(score), 2047);

    // Asynchronous reset with a note pending: clears now, no MISS afterwards
    tick(599, 1, 8'h20, 600, 8'h00);
    game_time = 10'd620;
    #2;
    reset = 1'b1;
    #1;
    check("s6_rst_valid", 32'(judge_valid), 0);
    check("s6_rst_score", 32'(score), 0);
    check("s6_rst_combo", 32'(combo), 0);
    check("s6_rst_max",   32'(max_combo), 0);
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    tick(620, 0, 8'h00, 0, 8'h00);
    check("s6_no_miss", 32'(judge_valid), 0);

    // Randomized traffic with advancing, wrapping game time
    rg = 700;
    for (int i = 0; i < 1500; i++) begin
      bit [7:0] nl;
      bit [7:0] k;
      bit       nv;
      rg = (rg + int'($urandom_range(0, 2))) % TMOD;
      nv = ($urandom_range(0, 2) == 0);
      nl = 8'($urandom);
      k  = 8'($urandom);
      tick(rg, nv, nl, rg + int'($urandom_range(0, 5)), k);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
